// File: rtl/pc_nzp_unit.sv
// pc_nzp_unit: per-thread next-PC and NZP flag unit.
// Computes the branch/fall-through PC, stores CMP flags, and latches RET.
//
// Ports:
//   clk, reset               clock and async active-high reset
//   enable                   thread active; low freezes all state
//   core_state               core phase (EXECUTE and UPDATE act here)
//   current_pc               PC of the instruction in flight
//   decoded_nzp              BR condition mask (N,Z,P)
//   decoded_immediate        BR target
//   decoded_pc_mux           instruction is BR
//   decoded_nzp_write_enable instruction is CMP
//   decoded_ret              instruction is RET
//   alu_out                  ALU result, [2:0] carries CMP flags
//   next_pc                  registered next PC
//   nzp_out                  registered flags (N,Z,P)
//   branch_taken             last EXECUTE redirected the PC
//   thread_done              sticky RET flag, cleared only by reset
module pc_nzp_unit #(
   parameter int PC_WIDTH = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic [2:0]          core_state,
   input  logic [PC_WIDTH-1:0] current_pc,
   input  logic [2:0]          decoded_nzp,
   input  logic [PC_WIDTH-1:0] decoded_immediate,
   input  logic                decoded_pc_mux,
   input  logic                decoded_nzp_write_enable,
   input  logic                decoded_ret,
   input  logic [7:0]          alu_out,
   output logic [PC_WIDTH-1:0] next_pc,
   output logic [2:0]          nzp_out,
   output logic                branch_taken,
   output logic                thread_done
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'b000,
      ST_FETCH   = 3'b001,
      ST_DECODE  = 3'b010,
      ST_REQUEST = 3'b011,
      ST_WAIT    = 3'b100,
      ST_EXECUTE = 3'b101,
      ST_UPDATE  = 3'b110,
      ST_DONE    = 3'b111
   } core_state_t;

   localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

   logic                active;
   logic                in_exec;
   logic                in_update;
   logic                match;
   logic                take_branch;
   logic [PC_WIDTH-1:0] pc_plus_one;

   // Only the flag bits of the ALU result matter here.
   logic unused_alu;
   assign unused_alu = ^alu_out[7:3];

   // A finished thread behaves exactly like a disabled one.
   assign active    = enable & ~thread_done;
   assign in_exec   = (core_state == ST_EXECUTE);
   assign in_update = (core_state == ST_UPDATE);

   // Flags come from the register only, so a CMP is seen by the
   // following instruction, never by the one in flight.
   assign match       = |(nzp_out & decoded_nzp);
   assign take_branch = decoded_pc_mux & match;

   // Natural wrap from all-ones to zero.
   assign pc_plus_one = current_pc + PC_ONE;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         next_pc      <= '0;
         nzp_out      <= 3'b000;
         branch_taken <= 1'b0;
         thread_done  <= 1'b0;
      end else if (active) begin
         if (in_exec) begin
            // RET wins over BR; the PC is left where it was.
            if (decoded_ret) begin
               thread_done  <= 1'b1;
               branch_taken <= 1'b0;
            end else if (take_branch) begin
               next_pc      <= decoded_immediate;
               branch_taken <= 1'b1;
            end else begin
               next_pc      <= pc_plus_one;
               branch_taken <= 1'b0;
            end
         end
         if (in_update && decoded_nzp_write_enable) begin
            nzp_out <= alu_out[2:0];
         end
      end
   end

endmodule
